// File: rtl/hw_output_stream_writer.sv
// Output stage of the camera pipeline: buffers gamma-curved pixels in a small
// FIFO, tags each one with end-of-line / end-of-frame from raster counters and
// hands them to the host stream side under valid/ready backpressure.
module hw_output_stream_writer #(
  parameter int WIDTH      = 16,
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_eol,
  output logic             out_eof,
  output logic             frame_done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef struct packed {
    logic             eof;
    logic             eol;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            push, pop;
  logic            at_eol, at_eof;
  entry_t          head;
  entry_t          wr_entry;

  // Ready comes from the registered count only, so a pop on a full FIFO
  // cannot open a slot in the same cycle.
  assign in_ready  = (count < CW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign at_eol = (x == XW'(IMG_W - 1));
  assign at_eof = at_eol & (y == YW'(IMG_H - 1));

  assign head     = mem[rd_ptr];
  assign wr_entry = '{eof: at_eof, eol: at_eol, data: in_data};

  // Output fields are forced to zero while nothing is buffered.
  assign out_data = out_valid ? head.data : '0;
  assign out_eol  = out_valid & head.eol;
  assign out_eof  = out_valid & head.eof;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // Pointers and occupancy; pointers wrap naturally at FIFO_DEPTH (power of 2).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Raster position of the next accepted pixel; advances on push only.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (push) begin
      if (at_eol) begin
        x <= '0;
        y <= at_eof ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // One-cycle pulse after the end-of-frame pixel leaves the FIFO.
  always_ff @(posedge clk) begin
    if (rst) frame_done <= 1'b0;
    else     frame_done <= pop & head.eof;
  end

endmodule
